// File: rtl/updown_pkg.sv
`default_nettype none
// =============================================================================
// Module  : updown_pkg
// Purpose : Shared types, phase codes and transition classifier for the decoder.
// Revision: 1.0
// =============================================================================
package updown_pkg;

    typedef enum logic [0:0] {PRIME, TRACK} state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {T_NONE, T_UP, T_DOWN, T_ILLEGAL} trans_t;

    // Phase code one step further in the "up" rotation 00->01->11->10->00.
    function automatic logic [1:0] next_up(input logic [1:0] ph);
        logic [1:0] res;
        case (ph)
            PH_00:   res = PH_01;
            PH_01:   res = PH_11;
            PH_11:   res = PH_10;
            default: res = PH_00;
        endcase
        return res;
    endfunction

    function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
        trans_t res;
        if (cur == prev)
            res = T_NONE;
        else if (cur == next_up(prev))
            res = T_UP;
        else if (prev == next_up(cur))
            res = T_DOWN;
        else
            res = T_ILLEGAL;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/updown_sync.sv
`default_nettype none
// =============================================================================
// Module  : updown_sync
// Purpose : Single-bit multi-stage synchroniser, async active-low reset to 0.
// Revision: 1.0
// =============================================================================
module updown_sync
    import updown_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            chain <= '0;
        else
            chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/updown_quad_decoder.sv
`default_nettype none
// =============================================================================
// Module  : updown_quad_decoder
// Purpose : Quadrature decoder with synchronised phases and wrapping up/down count.
// Revision: 1.0
// =============================================================================
module updown_quad_decoder
    import updown_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qa,
    input  logic             qb,
    input  logic             clr,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             err
);

    localparam int PCW = $clog2(SYNC_STAGES + 1);

    logic             a;
    logic             b;
    logic [1:0]       cur;
    state_t           state;
    state_t           state_nx;
    logic [PCW-1:0]   prime_cnt;
    logic [PCW-1:0]   prime_cnt_nx;
    logic [1:0]       prev;
    logic [1:0]       prev_nx;
    trans_t           trans;
    logic             step_nx;
    logic             err_nx;
    logic             dir_nx;
    logic [WIDTH-1:0] count_nx;

    updown_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d   (qa),
        .q   (a)
    );

    updown_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (qb),
        .q   (b)
    );

    assign cur = {a, b};

    always_comb begin
        state_nx     = state;
        prime_cnt_nx = prime_cnt;
        prev_nx      = prev;
        trans        = T_NONE;
        step_nx      = 1'b0;
        err_nx       = 1'b0;
        dir_nx       = dir;
        count_nx     = count;

        case (state)
            PRIME: begin
                // Wait for the synchroniser to fill before trusting {a,b} as a baseline.
                if (prime_cnt == PCW'(SYNC_STAGES)) begin
                    prev_nx  = cur;
                    state_nx = TRACK;
                end else begin
                    prime_cnt_nx = prime_cnt + PCW'(1);
                end
            end
            TRACK: begin
                trans   = classify(prev, cur);
                prev_nx = cur;
                case (trans)
                    T_UP: begin
                        step_nx  = 1'b1;
                        dir_nx   = 1'b1;
                        count_nx = count + WIDTH'(1);
                    end
                    T_DOWN: begin
                        step_nx  = 1'b1;
                        dir_nx   = 1'b0;
                        count_nx = count - WIDTH'(1);
                    end
                    T_ILLEGAL: err_nx = 1'b1;
                    default: ;
                endcase
            end
            default: state_nx = PRIME;
        endcase

        if (clr)
            count_nx = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PRIME;
            prime_cnt <= '0;
            prev      <= PH_00;
            step      <= 1'b0;
            err       <= 1'b0;
            dir       <= 1'b1;
            count     <= '0;
        end else begin
            state     <= state_nx;
            prime_cnt <= prime_cnt_nx;
            prev      <= prev_nx;
            step      <= step_nx;
            err       <= err_nx;
            dir       <= dir_nx;
            count     <= count_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_updown_quad_decoder.sv
`default_nettype none
// =============================================================================
// Module  : tb_updown_quad_decoder
// Purpose : Self-checking bench: vector table plus reset/clear corner sequences.
// Revision: 1.0
// =============================================================================
module tb_updown_quad_decoder;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             qa  = 1'b0;
    logic             qb  = 1'b0;
    logic             clr = 1'b0;
    logic             step;
    logic             dir;
    logic             err;
    logic [WIDTH-1:0] count;

    typedef struct {
        logic       qa;
        logic       qb;
        logic       step;
        logic       err;
        logic       dir;
        logic [3:0] count;
    } vec_t;

    typedef struct {
        logic       step;
        logic       err;
        logic       dir;
        logic [3:0] count;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [1:0] seq [4];

    updown_quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .rst   (rst),
        .qa    (qa),
        .qb    (qb),
        .clr   (clr),
        .step  (step),
        .dir   (dir),
        .count (count),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic a, input logic b, input logic s,
                                input logic e, input logic d, input logic [3:0] c);
        vec_t v;
        v.qa = a; v.qb = b; v.step = s; v.err = e; v.dir = d; v.count = c;
        return v;
    endfunction

    function automatic void add(input logic a, input logic b, input logic s,
                                input logic e, input logic d, input logic [3:0] c);
        vecs.push_back(mk(a, b, s, e, d, c));
    endfunction

    // Drive a phase pair; the decoded result must land exactly SYNC_STAGES edges after capture.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        e.step = v.step; e.err = v.err; e.dir = v.dir; e.count = v.count;
        qa = v.qa;
        qb = v.qb;
        sb.push_back(e);
        tick();
        tick();
        chk({tag, " early_step"}, step, 0);
        chk({tag, " early_err"}, err, 0);
        tick();
        e = sb.pop_front();
        chk({tag, " step"}, step, e.step);
        chk({tag, " err"}, err, e.err);
        chk({tag, " dir"}, dir, e.dir);
        chk({tag, " count"}, count, e.count);
        tick();
        chk({tag, " step_end"}, step, 0);
        chk({tag, " err_end"}, err, 0);
    endtask

    task automatic quiet(input int n, input logic [3:0] c, input logic d, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, " step"}, step, 0);
            chk({tag, " err"}, err, 0);
            chk({tag, " count"}, count, c);
            chk({tag, " dir"}, dir, d);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;

        // Up to count=4, reverse direction, then step below zero.
        add(0, 1, 1, 0, 1, 4'h1);
        add(1, 1, 1, 0, 1, 4'h2);
        add(1, 0, 1, 0, 1, 4'h3);
        add(0, 0, 1, 0, 1, 4'h4);
        add(1, 0, 1, 0, 0, 4'h3);
        add(0, 0, 1, 0, 1, 4'h4);
        add(1, 0, 1, 0, 0, 4'h3);
        add(1, 1, 1, 0, 0, 4'h2);
        add(0, 1, 1, 0, 0, 4'h1);
        add(0, 0, 1, 0, 0, 4'h0);
        add(1, 0, 1, 0, 0, 4'hF);
        for (int i = 0; i < 16; i++)
            add(seq[i % 4][1], seq[i % 4][0], 1, 0, 1, 4'(i));
        add(1, 1, 1, 0, 0, 4'hE);
        add(0, 1, 1, 0, 0, 4'hD);
        add(1, 0, 0, 1, 0, 4'hD);
        add(0, 0, 1, 0, 1, 4'hE);
        add(1, 1, 0, 1, 1, 4'hE);
        add(0, 1, 1, 0, 0, 4'hD);

        // Reset with both phases high: PRIME must absorb them silently.
        rst = 1'b0; qa = 1'b1; qb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset step", step, 0);
        chk("reset err", err, 0);
        chk("reset dir", dir, 1);
        chk("reset count", count, 0);
        rst = 1'b1;
        quiet(8, 4'h0, 1'b1, "prime11");

        rst = 1'b0; qa = 1'b0; qb = 1'b0;
        tick();
        rst = 1'b1;
        quiet(6, 4'h0, 1'b1, "prime00");

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_idle count", count, 0);
        chk("clr_idle dir", dir, 0);

        for (int i = 0; i < 7; i++)
            apply(mk(seq[(2 + i) % 4][1], seq[(2 + i) % 4][0], 1, 0, 1, 4'(i + 1)),
                  $sformatf("up7_%0d", i));

        // clr lands on the same edge that registers an up step.
        qa = 1'b0; qb = 1'b1;
        tick();
        tick();
        chk("pre_clr count", count, 7);
        chk("pre_clr step", step, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_step step", step, 1);
        chk("clr_step dir", dir, 1);
        chk("clr_step count", count, 0);
        chk("clr_step err", err, 0);
        tick();
        chk("post_clr step", step, 0);
        chk("post_clr count", count, 0);

        for (int i = 0; i < 5; i++)
            apply(mk(seq[(2 + i) % 4][1], seq[(2 + i) % 4][0], 1, 0, 1, 4'(i + 1)),
                  $sformatf("up5_%0d", i));

        // Asynchronous reset while a phase change sits in the synchroniser.
        qa = 1'b1; qb = 1'b0;
        tick();
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst count", count, 0);
        chk("async_rst dir", dir, 1);
        chk("async_rst step", step, 0);
        chk("async_rst err", err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        quiet(8, 4'h0, 1'b1, "reprime");
        apply(mk(0, 0, 1, 0, 1, 4'h1), "after_reprime");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_quad_decoder.md
# updown_quad_decoder

Quadrature decoder that turns two asynchronous encoder phases (qa, qb) into the direction/step control that drives the up/down position count, and keeps that position count itself. It sits at the input side of the counter path. It synchronises the phases, classifies each Gray-code transition as up, down or illegal, and outputs a registered step pulse, a direction flag, a wrapping position count and an error pulse.

## Interface
- WIDTH, 4: position counter width; count wraps modulo 2^WIDTH.
- SYNC_STAGES, 2: flip-flop stages per phase input in the synchroniser; legal range 2..4.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserting (0) clears all state immediately, release is synchronous to clk.
- qa  input  1  encoder phase A; asynchronous to clk.
- qb  input  1  encoder phase B; asynchronous to clk.
- clr  input  1  synchronous clear of count.
- step  output  1  one-cycle pulse per valid transition.
- dir  output  1  direction of the last valid transition; 1 = up, 0 = down.
- count  output  WIDTH  position count.
- err  output  1  one-cycle pulse per illegal (double-bit) transition.

## Operation
- Each phase passes through its own SYNC_STAGES-deep synchroniser. The synchronised pair is {a,b}, and prev holds the last accepted pair.
- FSM has two states, PRIME and TRACK:
  - PRIME is entered on reset. A stage counter counts SYNC_STAGES edges after rst release so the synchroniser fills. On the following edge: prev ← {a,b}, go to TRACK. No step and no err are produced in PRIME.
  - TRACK compares {a,b} against prev every cycle.
- Transition classes in TRACK:
  - Up: 00→01, 01→11, 11→10, 10→00. Result: step=1, dir←1, count←count+1.
  - Down: the reverse of each up transition. Result: step=1, dir←0, count←count−1.
  - Equal: no step, no err, nothing changes.
  - Illegal: 00↔11 or 01↔10. Result: err=1, step=0, dir and count unchanged.
  - prev ← {a,b} on every TRACK cycle, including illegal ones, so decoding resynchronises after an illegal transition.
- Arithmetic is unsigned WIDTH-bit with natural wrap: 4'hF+1→4'h0, 4'h0−1→4'hF. No saturation and no overflow flag.
- clr=1: count←0 on that edge, overriding any ±1 in the same cycle. step, dir and err are still reported normally for that cycle. clr is honoured in PRIME too.
- Reset values: step=0, err=0, dir=1, count=0, prev=00, synchroniser flops=0, FSM=PRIME.
- rst asserted mid-operation clears everything at once, including any in-flight synchroniser value. After release, PRIME repeats, so no spurious step appears even when qa/qb are non-zero.

## Timing
- step, err, dir and count are all registered outputs; none has a combinational path from any input.
- Latency: for a phase change captured at edge k, the outputs reflect it from edge k+SYNC_STAGES onward. For SYNC_STAGES=2, a change captured at edge k shows up at edge k+2.
- step and err each stay high for exactly one cycle per event and are never high together.
- Back-to-back valid transitions on consecutive synchronised cycles produce consecutive step pulses; none is dropped.
- Maximum trackable input rate is one phase change per clk cycle. Faster inputs may show up as illegal transitions and raise err.
- First possible step after rst release: edge SYNC_STAGES+2, counted from the first edge after release.

## Structure
- Package updown_pkg holds:
  - the FSM state enum {PRIME, TRACK};
  - the 2-bit phase-code constants PH_00, PH_01, PH_11, PH_10;
  - the transition class enum {T_NONE, T_UP, T_DOWN, T_ILLEGAL}.
- Sub-module updown_sync: a single-bit synchroniser with a SYNC_STAGES parameter, async active-low reset to 0. It is instantiated once for qa and once for qb.
- The top level contains the FSM, the prime counter, the transition classifier and the count/dir/step/err registers.

## Test plan
- Reset with qa=1, qb=1 held, then release rst → no step and no err, count stays 0, and dir=1 after PRIME completes.
- Four up transitions (00→01→11→10→00), each held 4 cycles → four single-cycle step pulses, dir=1, count=4, each pulse SYNC_STAGES edges after its input change.
- From count=0, one down transition 00→10 → step, dir=0, count=4'hF. Then 16 up transitions → count wraps back to 4'hF.
- Illegal jump 01→10 → a single err pulse, no step, count and dir unchanged. The next legal transition 10→00 is decoded as up.
- clr=1 in the same cycle an up step is decoded, with count=7 → count=0, step=1, dir=1.
- Assert rst mid-sequence while count=5 and a phase change is still in the synchroniser → count=0, dir=1, step=0 at once. After release, PRIME repeats with no spurious step.
